// File: rtl/blockmem2p_pkg.sv
// Shared types and sizing helpers for the two-port block memory.
// Combinational helpers only; no state.
// No flow control of its own.
package blockmem2p_pkg;

    // Same-address read-during-write behaviour seen on port B.
    typedef enum logic {
        RDW_WRITE_FIRST,
        RDW_READ_FIRST
    } rdw_mode_t;

    // Post-reset clear sequencer states.
    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } clr_state_t;

    // Address width for a given depth; at least one bit, so a depth of 1 still has a port.
    function automatic int f_addrwidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Number of byte lanes; the top lane may be only partly populated.
    function automatic int f_wewidth(input int width);
        return ((width - 1) / 8) + 1;
    endfunction

endpackage

// File: rtl/blockmem2p_clear_seq.sv
// Post-reset clear sequencer: walks every address once, writing zero, then enters RUN.
// Latency: exactly G_MEMDEPTH cycles of CLEAR after reset release.
// While clearing, init_busy is high and the top level ignores both ports.
module blockmem2p_clear_seq
    import blockmem2p_pkg::*;
#(
    parameter int G_MEMDEPTH       = 1024,
    parameter int G_CLEAR_ON_RESET = 1,
    parameter int G_ADDRWIDTH      = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   clr_we_o,
    output logic [G_ADDRWIDTH-1:0] clr_addr_o,
    output logic                   run_o,
    output logic                   init_busy_o
);

    localparam clr_state_t             C_RST_STATE = (G_CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    localparam logic [G_ADDRWIDTH-1:0] C_LAST_ADDR = G_ADDRWIDTH'(G_MEMDEPTH - 1);

    clr_state_t             state_q, state_d;
    logic [G_ADDRWIDTH-1:0] clr_addr_q, clr_addr_d;

    // State and clear address registers; reset always restarts clearing from address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= C_RST_STATE;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Next state: one word per cycle; leave CLEAR after the last word has been written.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == ST_CLEAR) begin
            clr_addr_d = clr_addr_q + G_ADDRWIDTH'(1);
            if (clr_addr_q == C_LAST_ADDR) begin
                state_d = ST_RUN;
            end
        end
    end

    // Outputs decoded from the registered state only, so init_busy is glitch-free.
    always_comb begin
        clr_we_o    = (state_q == ST_CLEAR);
        init_busy_o = (state_q == ST_CLEAR);
        run_o       = (state_q == ST_RUN);
        clr_addr_o  = clr_addr_q;
    end

endmodule

// File: rtl/blockmem2p_sync.sv
// Simple dual-port block RAM (A write, B read) with byte enables, post-reset clear and read-valid strobe.
// Read latency G_RDLATENCY (1 or 2) cycles, fully pipelined, one read per cycle.
// No backpressure: reads and writes are accepted every cycle except while init_busy is high.
module blockmem2p_sync
    import blockmem2p_pkg::*;
#(
    parameter int    G_MEMWIDTH       = 32,
    parameter int    G_MEMDEPTH       = 1024,
    parameter string G_INIT_FILE      = "",
    parameter int    G_RDLATENCY      = 1,
    parameter string G_RDW_MODE       = "WRITE_FIRST",
    parameter int    G_CLEAR_ON_RESET = 1,
    localparam int   G_WEWIDTH        = f_wewidth(G_MEMWIDTH),
    localparam int   G_ADDRWIDTH      = f_addrwidth(G_MEMDEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic [G_WEWIDTH-1:0]   wea,
    input  logic [G_ADDRWIDTH-1:0] addra,
    input  logic [G_MEMWIDTH-1:0]  dina,
    input  logic                   enb,
    input  logic [G_ADDRWIDTH-1:0] addrb,
    output logic [G_MEMWIDTH-1:0]  doutb,
    output logic                   doutb_valid,
    output logic                   init_busy
);

    // The array is stored in whole byte lanes so every lane uses the same write template;
    // padding bits above G_MEMWIDTH are written with zero and never observed.
    localparam int                     C_PADW  = 8 * G_WEWIDTH;
    localparam rdw_mode_t              C_RDW   = (G_RDW_MODE == "READ_FIRST") ? RDW_READ_FIRST
                                                                              : RDW_WRITE_FIRST;
    localparam logic [G_ADDRWIDTH:0]   C_DEPTH = (G_ADDRWIDTH + 1)'(G_MEMDEPTH);

    // Reject unsupported configurations at elaboration time.
    if (G_RDLATENCY != 1 && G_RDLATENCY != 2) begin : g_bad_latency
        $error("blockmem2p_sync: G_RDLATENCY must be 1 or 2");
    end
    if (G_RDW_MODE != "WRITE_FIRST" && G_RDW_MODE != "READ_FIRST") begin : g_bad_rdw
        $error("blockmem2p_sync: G_RDW_MODE must be WRITE_FIRST or READ_FIRST");
    end
    if (G_CLEAR_ON_RESET == 1 && G_INIT_FILE != "") begin : g_bad_init
        $error("blockmem2p_sync: G_INIT_FILE must be empty when G_CLEAR_ON_RESET=1");
    end

    logic                   clr_we;
    logic [G_ADDRWIDTH-1:0] clr_addr;
    logic                   run;

    blockmem2p_clear_seq #(
        .G_MEMDEPTH       (G_MEMDEPTH),
        .G_CLEAR_ON_RESET (G_CLEAR_ON_RESET),
        .G_ADDRWIDTH      (G_ADDRWIDTH)
    ) u_clear_seq (
        .clk         (clk),
        .rst         (rst),
        .clr_we_o    (clr_we),
        .clr_addr_o  (clr_addr),
        .run_o       (run),
        .init_busy_o (init_busy)
    );

    // Port qualification: out-of-range addresses only exist for non-power-of-two depths.
    logic in_range_a, in_range_b;
    logic wr_act, rd_req, ram_rd_en, coll;

    assign in_range_a = ({1'b0, addra} < C_DEPTH);
    assign in_range_b = ({1'b0, addrb} < C_DEPTH);
    assign wr_act     = run && ena && in_range_a;
    assign rd_req     = run && enb;
    assign ram_rd_en  = rd_req && in_range_b;
    // Only WRITE_FIRST needs to patch the read word; READ_FIRST returns the array output as is.
    assign coll       = (C_RDW == RDW_WRITE_FIRST) && rd_req && wr_act && in_range_b &&
                        (addra == addrb) && (|wea);

    logic [G_WEWIDTH-1:0]   mem_we;
    logic [G_ADDRWIDTH-1:0] mem_wa;
    logic [C_PADW-1:0]      mem_wd;
    logic [C_PADW-1:0]      wmask_pad;

    // Write-port mux: the clear sequencer owns the port while clearing, otherwise port A.
    always_comb begin
        mem_we = '0;
        mem_wa = addra;
        mem_wd = C_PADW'(dina);
        if (clr_we) begin
            mem_we = '1;
            mem_wa = clr_addr;
            mem_wd = '0;
        end else if (wr_act) begin
            mem_we = wea;
        end
    end

    // Bit-level view of the byte enables, used to merge written lanes into a colliding read.
    always_comb begin
        wmask_pad = '0;
        for (int i = 0; i < G_WEWIDTH; i++) begin
            wmask_pad[8*i +: 8] = {8{wea[i]}};
        end
    end

    logic [C_PADW-1:0] mem [G_MEMDEPTH];
    logic [C_PADW-1:0] ram_rd_q;

    // Array write: plain byte-enable template with no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < G_WEWIDTH; i++) begin
            if (mem_we[i]) begin
                mem[mem_wa][8*i +: 8] <= mem_wd[8*i +: 8];
            end
        end
    end

    // Array read: registered, read-first output; collision handling happens after this register.
    always_ff @(posedge clk) begin
        if (ram_rd_en) begin
            ram_rd_q <= mem[addrb];
        end
    end

    logic                  vld1_q;
    logic                  has_dat_q;
    logic                  oob_q;
    logic                  coll_q;
    logic [G_MEMWIDTH-1:0] bmask_q;
    logic [G_MEMWIDTH-1:0] bdat_q;

    // Read sideband captured alongside the array read; only updated by a read so doutb holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld1_q    <= 1'b0;
            has_dat_q <= 1'b0;
            oob_q     <= 1'b0;
            coll_q    <= 1'b0;
            bmask_q   <= '0;
            bdat_q    <= '0;
        end else begin
            vld1_q <= rd_req;
            if (rd_req) begin
                has_dat_q <= 1'b1;
                oob_q     <= !in_range_b;
                coll_q    <= coll;
                bmask_q   <= wmask_pad[G_MEMWIDTH-1:0];
                bdat_q    <= dina;
            end
        end
    end

    logic [G_MEMWIDTH-1:0] rd_word;
    logic [G_MEMWIDTH-1:0] stage1_dat;

    // First-stage read word: merge written lanes on collision, force zero out of range,
    // and present zero after reset until the first read completes.
    always_comb begin
        rd_word = ram_rd_q[G_MEMWIDTH-1:0];
        if (coll_q) begin
            rd_word = (bdat_q & bmask_q) | (ram_rd_q[G_MEMWIDTH-1:0] & ~bmask_q);
        end
        if (oob_q) begin
            rd_word = '0;
        end
        stage1_dat = has_dat_q ? rd_word : '0;
    end

    if (G_RDLATENCY == 2) begin : g_lat2
        logic [G_MEMWIDTH-1:0] dout2_q;
        logic                  vld2_q;

        // Extra output register; loads only when a first-stage read completes.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout2_q <= '0;
                vld2_q  <= 1'b0;
            end else begin
                vld2_q <= vld1_q;
                if (vld1_q) begin
                    dout2_q <= stage1_dat;
                end
            end
        end

        assign doutb       = dout2_q;
        assign doutb_valid = vld2_q;
    end else begin : g_lat1
        assign doutb       = stage1_dat;
        assign doutb_valid = vld1_q;
    end

endmodule

// File: tb/tb_blockmem2p_sync.sv
// Self-checking bench: three configurations driven by the same stimulus and scored per instance.
// A: depth 1024, latency 1, WRITE_FIRST, clear on reset; B: depth 1024, latency 2, READ_FIRST, clear on reset;
// C: depth 600, latency 1, WRITE_FIRST, contents kept across reset.
module tb_blockmem2p_sync;

    localparam int NDUT  = 3;
    localparam int DEPTH = 1024;
    localparam int NVEC  = 21;

    typedef struct {
        int          due;
        logic [31:0] dat;
    } exp_t;

    typedef struct {
        logic        ena;
        logic [3:0]  wea;
        logic [9:0]  addra;
        logic [31:0] dina;
        logic        enb;
        logic [9:0]  addrb;
        logic [31:0] xa;
        logic [31:0] xb;
        logic [31:0] xc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b0;
    logic        enb = 1'b0;
    logic [3:0]  wea = '0;
    logic [9:0]  addra = '0;
    logic [9:0]  addrb = '0;
    logic [31:0] dina = '0;

    logic [31:0] dout_s [NDUT];
    logic        vld_s  [NDUT];
    logic        busy_s [NDUT];

    int          lat [NDUT] = '{1, 2, 1};
    int          clr [NDUT] = '{1, 1, 0};
    exp_t        sb  [NDUT][$];
    int          busy_cnt [NDUT];
    logic [31:0] last_dat [NDUT];
    vec_t        tbl [NVEC];

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;
    int busy_hi = 0;

    always #5 clk = ~clk;

    blockmem2p_sync #(
        .G_MEMWIDTH(32), .G_MEMDEPTH(1024), .G_INIT_FILE(""), .G_RDLATENCY(1),
        .G_RDW_MODE("WRITE_FIRST"), .G_CLEAR_ON_RESET(1)
    ) u_dut_a (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(dout_s[0]), .doutb_valid(vld_s[0]), .init_busy(busy_s[0])
    );

    blockmem2p_sync #(
        .G_MEMWIDTH(32), .G_MEMDEPTH(1024), .G_INIT_FILE(""), .G_RDLATENCY(2),
        .G_RDW_MODE("READ_FIRST"), .G_CLEAR_ON_RESET(1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(dout_s[1]), .doutb_valid(vld_s[1]), .init_busy(busy_s[1])
    );

    blockmem2p_sync #(
        .G_MEMWIDTH(32), .G_MEMDEPTH(600), .G_INIT_FILE(""), .G_RDLATENCY(1),
        .G_RDW_MODE("WRITE_FIRST"), .G_CLEAR_ON_RESET(0)
    ) u_dut_c (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .addrb(addrb), .doutb(dout_s[2]), .doutb_valid(vld_s[2]), .init_busy(busy_s[2])
    );

    task automatic cmp(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h, expected %h (cycle %0d)", name, d, act, exp, cyc);
        end
    endtask

    function automatic vec_t v(input logic e_a, input logic [3:0] w, input logic [9:0] aa,
                               input logic [31:0] da, input logic e_b, input logic [9:0] ab,
                               input logic [31:0] xa, input logic [31:0] xb, input logic [31:0] xc);
        vec_t r;
        r.ena = e_a; r.wea = w; r.addra = aa; r.dina = da;
        r.enb = e_b; r.addrb = ab; r.xa = xa; r.xb = xb; r.xc = xc;
        return r;
    endfunction

    // Compare every instance after an edge: valid strobe, data or held data, and init_busy.
    task automatic check_outputs();
        for (int d = 0; d < NDUT; d++) begin
            logic exp_v;
            exp_t e;
            exp_v = (sb[d].size() > 0) && (sb[d][0].due == cyc);
            cmp("doutb_valid", d, {31'b0, vld_s[d]}, {31'b0, exp_v});
            if (exp_v) begin
                e = sb[d].pop_front();
                cmp("doutb", d, dout_s[d], e.dat);
                last_dat[d] = e.dat;
            end else begin
                cmp("doutb_hold", d, dout_s[d], last_dat[d]);
            end
            cmp("init_busy", d, {31'b0, busy_s[d]}, {31'b0, (busy_cnt[d] > 0)});
        end
        if (busy_s[0]) busy_hi++;
    endtask

    // Drive one cycle of stimulus, queue the expected read results, then check after the edge.
    task automatic step(input logic e_a, input logic [3:0] w, input logic [9:0] aa,
                        input logic [31:0] da, input logic e_b, input logic [9:0] ab,
                        input logic [31:0] xa, input logic [31:0] xb, input logic [31:0] xc);
        logic [31:0] x [NDUT];
        x[0] = xa; x[1] = xb; x[2] = xc;
        ena = e_a; wea = w; addra = aa; dina = da; enb = e_b; addrb = ab;
        for (int d = 0; d < NDUT; d++) begin
            if (busy_cnt[d] > 0) busy_cnt[d]--;
            else if (e_b) sb[d].push_back('{cyc + lat[d], x[d]});
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 10'd0, 32'h0, 32'h0, 32'h0);
    endtask

    // Assert reset, check the asynchronous outputs right away, hold one edge, release.
    task automatic do_reset();
        rst = 1'b1; ena = 1'b0; enb = 1'b0; wea = '0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            cmp("rst_valid", d, {31'b0, vld_s[d]}, 32'h0);
            cmp("rst_doutb", d, dout_s[d], 32'h0);
            cmp("rst_busy", d, {31'b0, busy_s[d]}, clr[d]);
            sb[d].delete();
            last_dat[d] = '0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        for (int d = 0; d < NDUT; d++) busy_cnt[d] = (clr[d] != 0) ? DEPTH : 0;
        busy_hi = busy_s[0] ? 1 : 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            ena  wea    addra    dina            enb  addrb    A             B             C
        tbl[0]  = v(1'b1, 4'hF, 10'd3,   32'h11223344, 1'b0, 10'd0,   32'h0,        32'h0,        32'h0);
        tbl[1]  = v(1'b1, 4'h5, 10'd3,   32'hAABBCCDD, 1'b0, 10'd0,   32'h0,        32'h0,        32'h0);
        tbl[2]  = v(1'b0, 4'h0, 10'd0,   32'h0,        1'b1, 10'd3,   32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD);
        tbl[3]  = v(1'b1, 4'hF, 10'd0,   32'hA0,       1'b0, 10'd0,   32'h0,        32'h0,        32'h0);
        tbl[4]  = v(1'b1, 4'hF, 10'd1,   32'hA1,       1'b0, 10'd0,   32'h0,        32'h0,        32'h0);
        tbl[5]  = v(1'b1, 4'hF, 10'd2,   32'hA2,       1'b0, 10'd0,   32'h0,        32'h0,        32'h0);
        tbl[6]  = v(1'b0, 4'h0, 10'd0,   32'h0,        1'b1, 10'd0,   32'hA0,       32'hA0,       32'hA0);
        tbl[7]  = v(1'b0, 4'h0, 10'd0,   32'h0,        1'b1, 10'd1,   32'hA1,       32'hA1,       32'hA1);
        tbl[8]  = v(1'b0, 4'h0, 10'd0,   32'h0,        1'b1, 10'd2,   32'hA2,       32'hA2,       32'hA2);
        tbl[9]  = v(1'b1, 4'hF, 10'd7,   32'h01020304, 1'b0, 10'd0,   32'h0,        32'h0,        32'h0);
        tbl[10] = v(1'b1, 4'h3, 10'd7,   32'hFFFFFFFF, 1'b1, 10'd7,   32'h0102FFFF, 32'h01020304, 32'h0102FFFF);
        tbl[11] = v(1'b0, 4'h0, 10'd0,   32'h0,        1'b1, 10'd7,   32'h0102FFFF, 32'h0102FFFF, 32'h0102FFFF);
        tbl[12] = v(1'b0, 4'hF, 10'd7,   32'h0,        1'b0, 10'd0,   32'h0,        32'h0,        32'h0);
        tbl[13] = v(1'b1, 4'h0, 10'd7,   32'h0,        1'b1, 10'd7,   32'h0102FFFF, 32'h0102FFFF, 32'h0102FFFF);
        tbl[14] = v(1'b0, 4'h0, 10'd0,   32'h0,        1'b0, 10'd0,   32'h0,        32'h0,        32'h0);
        tbl[15] = v(1'b1, 4'hF, 10'd599, 32'h99,       1'b0, 10'd0,   32'h0,        32'h0,        32'h0);
        tbl[16] = v(1'b1, 4'hF, 10'd700, 32'h55,       1'b0, 10'd0,   32'h0,        32'h0,        32'h0);
        tbl[17] = v(1'b0, 4'h0, 10'd0,   32'h0,        1'b1, 10'd700, 32'h55,       32'h55,       32'h0);
        tbl[18] = v(1'b0, 4'h0, 10'd0,   32'h0,        1'b1, 10'd599, 32'h99,       32'h99,       32'h99);
        tbl[19] = v(1'b1, 4'h4, 10'd7,   32'hAAAAAAAA, 1'b1, 10'd7,   32'h01AAFFFF, 32'h0102FFFF, 32'h01AAFFFF);
        tbl[20] = v(1'b0, 4'h0, 10'd0,   32'h0,        1'b1, 10'd7,   32'h01AAFFFF, 32'h01AAFFFF, 32'h01AAFFFF);

        #2;
        do_reset();

        // Clear after reset: write and read attempts during clear must be ignored.
        step(1'b1, 4'hF, 10'd5, 32'hDEADBEEF, 1'b1, 10'd5, 32'h0, 32'h0, 32'hDEADBEEF);
        while (busy_cnt[0] > 0)
            step(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd5, 32'h0, 32'h0, 32'hDEADBEEF);
        cmp("clear_cycles", 0, busy_hi, DEPTH);
        step(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd5, 32'h0, 32'h0, 32'hDEADBEEF);

        // Byte enables, latency, collisions, no-op writes, out-of-range addresses.
        for (int i = 0; i < NVEC; i++)
            step(tbl[i].ena, tbl[i].wea, tbl[i].addra, tbl[i].dina, tbl[i].enb, tbl[i].addrb,
                 tbl[i].xa, tbl[i].xb, tbl[i].xc);
        repeat (3) idle();

        // Reset while reads are in flight: valid must drop at once and pending reads vanish.
        step(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd599, 32'h99, 32'h99, 32'h99);
        step(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd3, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD);
        do_reset();

        // Uncleared instance keeps its contents; reset again with the clear address at 300.
        step(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd599, 32'h0, 32'h0, 32'h99);
        repeat (299) idle();
        do_reset();
        while (busy_cnt[0] > 0) idle();
        cmp("reclear_cycles", 0, busy_hi, DEPTH);

        step(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd3, 32'h0, 32'h0, 32'h11BB33DD);
        step(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd599, 32'h0, 32'h0, 32'h99);
        repeat (3) idle();
        for (int d = 0; d < NDUT; d++) cmp("sb_drained", d, sb[d].size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
